// File: rtl/settings_bus_arbiter.sv
// Merges several per-channel settings buses onto one shared settings bus.
// Each input has its own FIFO; a round-robin arbiter drains them under downstream ready.
module settings_bus_arbiter #(
  parameter int NUM_BUSES = 2,
  parameter int AWIDTH    = 8,
  parameter int DWIDTH    = 32,
  parameter int FIFO_SIZE = 4,
  parameter int ADDR_MIN  = 0,
  parameter int ADDR_MAX  = (1 << AWIDTH) - 1,
  parameter int SRC_WIDTH = (NUM_BUSES > 1) ? $clog2(NUM_BUSES) : 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic [NUM_BUSES-1:0]        in_set_stb,
  input  logic [NUM_BUSES*AWIDTH-1:0] in_set_addr,
  input  logic [NUM_BUSES*DWIDTH-1:0] in_set_data,
  input  logic                        ready,
  output logic                        out_set_stb,
  output logic [AWIDTH-1:0]           out_set_addr,
  output logic [DWIDTH-1:0]           out_set_data,
  output logic [SRC_WIDTH-1:0]        out_set_src,
  output logic [NUM_BUSES-1:0]        overflow
);

  localparam int DEPTH = 1 << FIFO_SIZE;
  localparam int EW    = AWIDTH + DWIDTH;
  localparam logic [FIFO_SIZE:0]   FULL_CNT  = (FIFO_SIZE+1)'(DEPTH);
  localparam logic [SRC_WIDTH-1:0] LAST_INIT = SRC_WIDTH'(NUM_BUSES - 1);
  // Window bounds carried one bit wider so full-range windows never fold into constant compares.
  localparam logic [AWIDTH:0]      WIN_LO    = (AWIDTH+1)'(ADDR_MIN);
  localparam logic [AWIDTH:0]      WIN_HI    = (AWIDTH+1)'(ADDR_MAX) + (AWIDTH+1)'(1);

  function automatic logic in_window(input logic [AWIDTH-1:0] a);
    logic [AWIDTH:0] ax;
    ax = {1'b0, a};
    return ((ax + (AWIDTH+1)'(1)) > WIN_LO) && (ax < WIN_HI);
  endfunction

  logic [EW-1:0]        fifo_mem [NUM_BUSES][DEPTH];
  logic [FIFO_SIZE-1:0] wr_ptr_q [NUM_BUSES];
  logic [FIFO_SIZE-1:0] wr_ptr_d [NUM_BUSES];
  logic [FIFO_SIZE-1:0] rd_ptr_q [NUM_BUSES];
  logic [FIFO_SIZE-1:0] rd_ptr_d [NUM_BUSES];
  logic [FIFO_SIZE:0]   cnt_q    [NUM_BUSES];
  logic [FIFO_SIZE:0]   cnt_d    [NUM_BUSES];

  logic [NUM_BUSES-1:0] push;
  logic [NUM_BUSES-1:0] drop;
  logic [NUM_BUSES-1:0] pop;

  logic                 out_stb_q,  out_stb_d;
  logic [AWIDTH-1:0]    out_addr_q, out_addr_d;
  logic [DWIDTH-1:0]    out_data_q, out_data_d;
  logic [SRC_WIDTH-1:0] out_src_q,  out_src_d;
  logic [SRC_WIDTH-1:0] last_grant_q, last_grant_d;
  logic [NUM_BUSES-1:0] ovf_q, ovf_d;

  logic                 gnt_vld;
  logic [SRC_WIDTH-1:0] gnt_idx;
  logic [SRC_WIDTH-1:0] cand_idx;
  logic [EW-1:0]        head;
  int                   cand;

  // Full is judged on the registered count, so a same-cycle pop never frees room for a push.
  always_comb begin
    push = '0;
    drop = '0;
    for (int i = 0; i < NUM_BUSES; i++) begin
      if (in_set_stb[i] && !clear && in_window(in_set_addr[AWIDTH*i +: AWIDTH])) begin
        if (cnt_q[i] == FULL_CNT) drop[i] = 1'b1;
        else                      push[i] = 1'b1;
      end
    end
  end

  // Descending scan so the lowest offset from last_grant+1 wins.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = last_grant_q;
    cand     = 0;
    cand_idx = '0;
    for (int k = NUM_BUSES; k >= 1; k--) begin
      cand = int'(last_grant_q) + k;
      if (cand >= NUM_BUSES) cand = cand - NUM_BUSES;
      cand_idx = SRC_WIDTH'(cand);
      if (cnt_q[cand_idx] != '0) begin
        gnt_vld = 1'b1;
        gnt_idx = cand_idx;
      end
    end
  end

  assign head = fifo_mem[gnt_idx][rd_ptr_q[gnt_idx]];

  always_comb begin
    out_stb_d    = 1'b0;
    out_addr_d   = out_addr_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;
    ovf_d        = ovf_q;
    pop          = '0;
    for (int i = 0; i < NUM_BUSES; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      cnt_d[i]    = cnt_q[i];
    end
    if (clear) begin
      ovf_d        = '0;
      last_grant_d = LAST_INIT;
      for (int i = 0; i < NUM_BUSES; i++) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
        cnt_d[i]    = '0;
      end
    end else begin
      if (ready && gnt_vld) begin
        out_stb_d    = 1'b1;
        out_addr_d   = head[EW-1 -: AWIDTH];
        out_data_d   = head[DWIDTH-1:0];
        out_src_d    = gnt_idx;
        last_grant_d = gnt_idx;
        pop[gnt_idx] = 1'b1;
      end
      ovf_d = ovf_q | drop;
      for (int i = 0; i < NUM_BUSES; i++) begin
        if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + FIFO_SIZE'(1);
        if (pop[i])  rd_ptr_d[i] = rd_ptr_q[i] + FIFO_SIZE'(1);
        cnt_d[i] = cnt_q[i] + (FIFO_SIZE+1)'(push[i]) - (FIFO_SIZE+1)'(pop[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BUSES; i++) begin
      if (push[i]) fifo_mem[i][wr_ptr_q[i]] <= {in_set_addr[AWIDTH*i +: AWIDTH],
                                                in_set_data[DWIDTH*i +: DWIDTH]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_stb_q    <= 1'b0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      out_src_q    <= '0;
      last_grant_q <= LAST_INIT;
      ovf_q        <= '0;
      for (int i = 0; i < NUM_BUSES; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      out_stb_q    <= out_stb_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
      ovf_q        <= ovf_d;
      for (int i = 0; i < NUM_BUSES; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  assign out_set_stb  = out_stb_q;
  assign out_set_addr = out_addr_q;
  assign out_set_data = out_data_q;
  assign out_set_src  = out_src_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_settings_bus_arbiter.sv
// Scoreboard bench for settings_bus_arbiter: 4 buses, depth-4 FIFOs, window 0x80..0xFF.
module tb_settings_bus_arbiter;
  localparam int NB = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int FS = 2;
  localparam int SW = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              clear = 1'b0;
  logic              ready = 1'b0;
  logic [NB-1:0]     in_set_stb = '0;
  logic [NB*AW-1:0]  in_set_addr = '0;
  logic [NB*DW-1:0]  in_set_data = '0;
  logic              out_set_stb;
  logic [AW-1:0]     out_set_addr;
  logic [DW-1:0]     out_set_data;
  logic [SW-1:0]     out_set_src;
  logic [NB-1:0]     overflow;

  settings_bus_arbiter #(
    .NUM_BUSES(NB), .AWIDTH(AW), .DWIDTH(DW), .FIFO_SIZE(FS),
    .ADDR_MIN(128), .ADDR_MAX(255), .SRC_WIDTH(SW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_set_stb(in_set_stb), .in_set_addr(in_set_addr), .in_set_data(in_set_data),
    .ready(ready),
    .out_set_stb(out_set_stb), .out_set_addr(out_set_addr), .out_set_data(out_set_data),
    .out_set_src(out_set_src), .overflow(overflow)
  );

  typedef struct {
    logic [SW-1:0] src;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic rdy_last = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rdy_last <= ready;
  end

  exp_t m_e;
  always @(negedge clk) begin
    if (out_set_stb !== 1'b0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: actual stb=%b src=%0d addr=%h data=%h cyc=%0d, required no pulse",
                 out_set_stb, out_set_src, out_set_addr, out_set_data, cyc);
      end else begin
        m_e = sb.pop_front();
        if (out_set_stb !== 1'b1 || out_set_src !== m_e.src || out_set_addr !== m_e.addr ||
            out_set_data !== m_e.data || (m_e.cyc >= 0 && cyc != m_e.cyc) || rdy_last !== 1'b1) begin
          errors++;
          $display("FAIL pulse: actual src=%0d addr=%h data=%h cyc=%0d prev_ready=%b, required src=%0d addr=%h data=%h cyc=%0d prev_ready=1",
                   out_set_src, out_set_addr, out_set_data, cyc, rdy_last,
                   m_e.src, m_e.addr, m_e.data, m_e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(negedge clk);
    in_set_stb = '0;
  endtask

  task automatic drive(input int b, input logic [AW-1:0] a, input logic [DW-1:0] d);
    in_set_stb[b]            = 1'b1;
    in_set_addr[AW*b +: AW]  = a;
    in_set_data[DW*b +: DW]  = d;
  endtask

  task automatic expect_w(input int b, input logic [AW-1:0] a, input logic [DW-1:0] d, input int c);
    exp_t t;
    t.src  = SW'(b);
    t.addr = a;
    t.data = d;
    t.cyc  = c;
    sb.push_back(t);
  endtask

  task automatic do_clear();
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_queue_empty", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_stb", 64'(out_set_stb), 64'd0);
    chk("reset_addr", 64'(out_set_addr), 64'd0);
    chk("reset_data", 64'(out_set_data), 64'd0);
    chk("reset_src", 64'(out_set_src), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    reset_n = 1'b1;

    // Single write, two-cycle latency
    ready = 1'b1;
    step();
    drive(1, 8'h90, 32'hDEADBEEF);
    expect_w(1, 8'h90, 32'hDEADBEEF, cyc + 2);
    step();
    drain();

    // Fairness: all buses, three rounds
    do_clear();
    ready = 1'b1;
    step();
    c0 = cyc;
    for (int j = 0; j < 12; j++)
      expect_w(j % 4, AW'(8'h80 + (j % 4) * 4 + j / 4), DW'((j % 4) * 16 + j / 4), c0 + 2 + j);
    for (int k = 0; k < 3; k++) begin
      for (int b = 0; b < NB; b++) drive(b, AW'(8'h80 + b * 4 + k), DW'(b * 16 + k));
      step();
    end
    drain();

    // Backpressure with toggling ready
    do_clear();
    ready = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      drive(0, AW'(8'hA0 + k), DW'(32'h100 + k));
      expect_w(0, AW'(8'hA0 + k), DW'(32'h100 + k), -1);
      step();
    end
    for (int i = 0; i < 10; i++) begin
      ready = (i % 2 == 0);
      step();
    end
    ready = 1'b1;
    drain();
    chk("bp_overflow", 64'(overflow), 64'd0);

    // Overflow: six strobes into a depth-4 FIFO
    do_clear();
    ready = 1'b0;
    step();
    for (int k = 0; k < 6; k++) begin
      drive(0, 8'h84, DW'(k));
      if (k < 4) expect_w(0, 8'h84, DW'(k), -1);
      step();
    end
    chk("ovf_set", 64'(overflow), 64'h1);
    ready = 1'b1;
    drain();
    chk("ovf_sticky", 64'(overflow), 64'h1);

    // Push to a full FIFO in the same cycle as a pop is still dropped
    do_clear();
    chk("ovf_cleared", 64'(overflow), 64'd0);
    ready = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      drive(0, 8'h88, DW'(32'h20 + k));
      expect_w(0, 8'h88, DW'(32'h20 + k), -1);
      step();
    end
    ready = 1'b1;
    drive(0, 8'h88, 32'h24);
    step();
    drain();
    chk("full_pop_overflow", 64'(overflow), 64'h1);

    // Address window lower bound
    do_clear();
    ready = 1'b1;
    step();
    drive(3, 8'h7F, 32'h7F7F);
    step();
    drive(3, 8'h80, 32'h8080);
    expect_w(3, 8'h80, 32'h8080, cyc + 2);
    step();
    drain();
    chk("filter_overflow", 64'(overflow), 64'd0);

    // Clear mid-stream with ten queued entries
    do_clear();
    ready = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      for (int b = 0; b < NB; b++)
        if (k < 2 || b < 2) drive(b, AW'(8'h90 + b), DW'(32'h700 + b * 16 + k));
      step();
    end
    clear = 1'b1;
    ready = 1'b1;
    drive(2, 8'h90, 32'hBAD);
    step();
    clear = 1'b0;
    chk("clear_stb", 64'(out_set_stb), 64'd0);
    repeat (4) step();
    chk("clear_overflow", 64'(overflow), 64'd0);
    drive(0, 8'hC0, 32'hC0C0);
    drive(2, 8'hC2, 32'hC2C2);
    expect_w(0, 8'hC0, 32'hC0C0, cyc + 2);
    expect_w(2, 8'hC2, 32'hC2C2, cyc + 3);
    step();
    drain();

    // Reset mid-stream with queued entries and a set overflow flag
    ready = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      drive(1, 8'hD0, DW'(32'h900 + k));
      if (k < 2) drive(3, 8'hD3, DW'(32'h930 + k));
      step();
    end
    chk("pre_reset_overflow", 64'(overflow), 64'h2);
    reset_n = 1'b0;
    ready = 1'b1;
    step();
    chk("mid_reset_stb", 64'(out_set_stb), 64'd0);
    chk("mid_reset_addr", 64'(out_set_addr), 64'd0);
    chk("mid_reset_data", 64'(out_set_data), 64'd0);
    chk("mid_reset_src", 64'(out_set_src), 64'd0);
    chk("mid_reset_overflow", 64'(overflow), 64'd0);
    reset_n = 1'b1;
    repeat (4) step();
    drive(3, 8'hE3, 32'hE3E3);
    drive(1, 8'hE1, 32'hE1E1);
    expect_w(1, 8'hE1, 32'hE1E1, cyc + 2);
    expect_w(3, 8'hE3, 32'hE3E3, cyc + 3);
    step();
    drain();
    chk("post_reset_overflow", 64'(overflow), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
